udp_app_tx_ctrl: RTL

UDP_APP_TX_CTRL -- requirements
Module: udp_app_tx_ctrl

---
 rtl/udp_app_tx_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/udp_app_tx_ctrl.sv
// UDP application transmit controller: accepts a length-checked send request, buffers the payload, then streams it out.
// Optional build macro UDP_TX_PAD_EN pads short payloads with 8'h00 up to an 18-byte stream.
module udp_app_tx_ctrl #(
    parameter logic [15:0] MAX_LEN = 16'd1472,
    parameter int          ADDR_W  = 11
) (
    input  logic        rgmii_clk,
    input  logic        rstn,
    input  logic        app_data_request,
    input  logic [15:0] app_data_length,
    output logic        udp_send_ack,
    input  logic        app_data_in_valid,
    input  logic [7:0]  app_data_in,
    output logic        udp_tx_valid,
    output logic [7:0]  udp_tx_data,
    output logic        udp_tx_last,
    input  logic        udp_tx_ready,
    output logic [15:0] udp_tx_length,
    output logic        tx_done,
    output logic        len_error,
    output logic        busy
);

    // state  | meaning
    // IDLE   | waiting for a request; bad lengths pulse len_error
    // ACK    | one-cycle grant, udp_send_ack high
    // FILL   | writing payload bytes into the buffer
    // STREAM | reading buffer out to the framer with backpressure
    // DONE   | one-cycle tx_done pulse
    typedef enum logic [2:0] {IDLE, ACK, FILL, STREAM, DONE} state_t;

    state_t      state;
    logic [15:0] len_q;
    logic [15:0] stream_len;
    logic [15:0] wr_cnt;
    logic [15:0] rd_cnt;
    logic [15:0] req_stream_len;
    logic [7:0]  mem [0:(2**ADDR_W)-1];
    logic [7:0]  rd_data;
    logic        s1_valid;
    logic        s1_last;
    logic        s1_pad;
    logic        wr_en;
    logic        out_load;
    logic        rd_issue;

`ifdef UDP_TX_PAD_EN
    localparam logic [15:0] PAD_LEN = 16'd18;
    assign req_stream_len = (app_data_length < PAD_LEN) ? PAD_LEN : app_data_length;
`else
    assign req_stream_len = app_data_length;
`endif

    assign wr_en    = (state == FILL) && app_data_in_valid;
    assign out_load = !udp_tx_valid || udp_tx_ready;
    // Stage 1 holds the byte just read; refill it whenever it is empty or moving to the output register.
    assign rd_issue = (state == STREAM) && (rd_cnt < stream_len) && (!s1_valid || out_load);

    always_ff @(posedge rgmii_clk) begin
        if (wr_en) begin
            mem[wr_cnt[ADDR_W-1:0]] <= app_data_in;
        end
        if (rd_issue) begin
            rd_data <= mem[rd_cnt[ADDR_W-1:0]];
        end
    end

    always_ff @(posedge rgmii_clk or negedge rstn) begin
        if (!rstn) begin
            state         <= IDLE;
            len_q         <= 16'd0;
            stream_len    <= 16'd0;
            wr_cnt        <= 16'd0;
            rd_cnt        <= 16'd0;
            s1_valid      <= 1'b0;
            s1_last       <= 1'b0;
            s1_pad        <= 1'b0;
            udp_send_ack  <= 1'b0;
            udp_tx_valid  <= 1'b0;
            udp_tx_data   <= 8'h00;
            udp_tx_last   <= 1'b0;
            udp_tx_length <= 16'd0;
            tx_done       <= 1'b0;
            len_error     <= 1'b0;
            busy          <= 1'b0;
        end else begin
            udp_send_ack <= 1'b0;
            tx_done      <= 1'b0;
            len_error    <= 1'b0;
            case (state)
                IDLE: begin
                    if (app_data_request) begin
                        if (app_data_length == 16'd0 || app_data_length > MAX_LEN) begin
                            len_error <= 1'b1;
                        end else begin
                            len_q         <= app_data_length;
                            stream_len    <= req_stream_len;
                            udp_tx_length <= req_stream_len;
                            wr_cnt        <= 16'd0;
                            udp_send_ack  <= 1'b1;
                            busy          <= 1'b1;
                            state         <= ACK;
                        end
                    end
                end
                ACK: begin
                    state <= FILL;
                end
                FILL: begin
                    if (app_data_in_valid) begin
                        wr_cnt <= wr_cnt + 16'd1;
                        if (wr_cnt == len_q - 16'd1) begin
                            rd_cnt   <= 16'd0;
                            s1_valid <= 1'b0;
                            state    <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (rd_issue) begin
                        rd_cnt   <= rd_cnt + 16'd1;
                        s1_valid <= 1'b1;
                        s1_last  <= (rd_cnt == stream_len - 16'd1);
                        s1_pad   <= (rd_cnt >= len_q);
                    end else if (out_load) begin
                        s1_valid <= 1'b0;
                    end
                    if (out_load) begin
                        udp_tx_valid <= s1_valid;
                        udp_tx_last  <= s1_valid && s1_last;
                        if (s1_valid) begin
                            udp_tx_data <= s1_pad ? 8'h00 : rd_data;
                        end
                    end
                    if (udp_tx_valid && udp_tx_ready && udp_tx_last) begin
                        udp_tx_valid <= 1'b0;
                        udp_tx_last  <= 1'b0;
                        tx_done      <= 1'b1;
                        state        <= DONE;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
